// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial arbiter between instruction fetch (IF), the MEM
// stage and an 8-bit external memory bus. 1/2/4-byte requests are turned into
// consecutive single-byte bus cycles; read bytes are assembled little-endian
// and completion is signalled by a one-cycle done pulse per requester.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise MEM has fixed priority over IF.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic [31:0] bus_a,
    output logic        bus_wr
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;          // 1 = MEM owns the transaction
    logic [31:0] base_q, base_d;
    logic [1:0]  last_q, last_d;            // index of the final byte (N-1)
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;              // index of the byte on the bus
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] bus_a_q, bus_a_d;
    logic [7:0]  bus_dout_q, bus_dout_d;
    logic        bus_wr_q, bus_wr_d;

    logic        if_elig, mem_elig;
    logic        grant_mem, grant_if, start_if, abort_if;
    logic [1:0]  cnt_nx;
    logic [1:0]  mem_last;

`ifdef MEM_ARB_RR_EN
    logic        last_grant_q, last_grant_d;  // 1 = MEM was granted last
`endif

    // Grant decision: a requester is ineligible while its own done pulse is up
    always_comb begin
        if_elig  = if_req  & ~if_done_q;
        mem_elig = mem_req & ~mem_done_q;
`ifdef MEM_ARB_RR_EN
        grant_mem = mem_elig & (~if_elig | ~last_grant_q);
`else
        grant_mem = mem_elig;
`endif
        grant_if = if_elig & ~grant_mem;
        start_if = grant_if & ~if_flush;
        abort_if = (state_q == RD) & ~owner_q & if_flush;
        cnt_nx   = cnt_q + 2'd1;
        case (mem_size)
            2'b00:   mem_last = 2'd0;
            2'b01:   mem_last = 2'd1;
            default: mem_last = 2'd3;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else if (ready)
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_mem)
                    state_d = mem_we ? WR : RD;
                else if (start_if)
                    state_d = RD;
            end
            RD: begin
                if (abort_if || cnt_q == last_q)
                    state_d = IDLE;
            end
            WR: begin
                if (cnt_q == last_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; bus outputs fall back to idle values
    always_comb begin
        owner_d     = owner_q;
        base_d      = base_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        bus_a_d     = '0;
        bus_dout_d  = '0;
        bus_wr_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    owner_d = 1'b1;
                    base_d  = mem_addr;
                    last_d  = mem_last;
                    wdata_d = mem_wdata;
                    cnt_d   = 2'd0;
                    rbuf_d  = '0;
                    bus_a_d = mem_addr;
                    if (mem_we) begin
                        bus_dout_d = mem_wdata[7:0];
                        bus_wr_d   = 1'b1;
                    end
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (start_if) begin
                    owner_d = 1'b0;
                    base_d  = if_addr;
                    last_d  = 2'd3;
                    cnt_d   = 2'd0;
                    rbuf_d  = '0;
                    bus_a_d = if_addr;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            RD: begin
                if (!abort_if) begin
                    rbuf_d[{cnt_q, 3'b000} +: 8] = bus_din;
                    if (cnt_q == last_q) begin
                        if (owner_q) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = rbuf_d;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_d;
                        end
                    end else begin
                        cnt_d   = cnt_nx;
                        bus_a_d = base_q + {30'd0, cnt_nx};
                    end
                end
            end
            WR: begin
                if (cnt_q == last_q) begin
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_nx;
                    bus_a_d    = base_q + {30'd0, cnt_nx};
                    bus_dout_d = wdata_q[{cnt_nx, 3'b000} +: 8];
                    bus_wr_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; everything freezes while ready is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q     <= 1'b0;
            base_q      <= '0;
            last_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            bus_a_q     <= '0;
            bus_dout_q  <= '0;
            bus_wr_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else if (ready) begin
            owner_q     <= owner_d;
            base_q      <= base_d;
            last_q      <= last_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rbuf_q      <= rbuf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            bus_a_q     <= bus_a_d;
            bus_dout_q  <= bus_dout_d;
            bus_wr_q    <= bus_wr_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Write strobe is suppressed while the bus is paused
    assign bus_wr    = bus_wr_q & ready;
    assign bus_a     = bus_a_q;
    assign bus_dout  = bus_dout_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference model (byte memory image plus grant rules).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  bus_din;
    logic [7:0]  bus_dout;
    logic [31:0] bus_a;
    logic        bus_wr;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .bus_a     (bus_a),
        .bus_wr    (bus_wr)
    );

    always #5 clk = ~clk;

    // Initial memory contents, shared by the bus memory and the model image
    function automatic logic [7:0] pat(input logic [15:0] a);
        logic [7:0] r;
        case (a)
            16'h0100: r = 8'h13;
            16'h0101: r = 8'h05;
            16'h0102: r = 8'h00;
            16'h0103: r = 8'h00;
            default:  r = (a[7:0] * 8'd29) ^ a[15:8] ^ 8'hA5;
        endcase
        return r;
    endfunction

    // Bus-side memory: combinational read, write at the edge when bus_wr is high
    logic [7:0]  mem [0:65535];
    int unsigned wr_count = 0;
    assign bus_din = mem[bus_a[15:0]];

    initial begin
        for (int unsigned i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        forever begin
            @(posedge clk);
            if (bus_wr) begin
                mem[bus_a[15:0]] = bus_dout;
                wr_count++;
            end
        end
    end

    // Reference model state
    logic [7:0] ref_mem [0:65535];
    bit         last_mem;

    function automatic int unsigned nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".bus_a"},     bus_a,            32'h0);
        chk({tag, ".bus_dout"},  {24'd0, bus_dout}, 32'h0);
        chk({tag, ".bus_wr"},    {31'd0, bus_wr},  32'h0);
        chk({tag, ".if_done"},   {31'd0, if_done}, 32'h0);
        chk({tag, ".mem_done"},  {31'd0, mem_done}, 32'h0);
    endtask

    task automatic raise(input bit is_mem, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (is_mem) begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_size  = size;
            mem_addr  = addr;
            mem_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
    endtask

    // Follows one transaction accepted at the next rising edge, through its done cycle
    task automatic serve(input bit is_mem, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int unsigned stall_j, input int unsigned stall_len);
        int unsigned n;
        bit          wr;
        logic [31:0] a, exp_rd, exp_a, sh;
        logic [7:0]  exp_dout;
        logic        exp_done;
        int unsigned wc0;
        n      = is_mem ? nbytes(size) : 4;
        wr     = is_mem & we;
        exp_rd = '0;
        for (int unsigned k = 0; k < n; k++) begin
            a  = addr + k;
            sh = wdata >> (8 * k);
            if (wr) ref_mem[a[15:0]] = sh[7:0];
            else    exp_rd = exp_rd | ({24'd0, ref_mem[a[15:0]]} << (8 * k));
        end
        wc0 = wr_count;
        for (int unsigned j = 1; j <= n + 1; j++) begin
            @(negedge clk);
            if (j <= n) begin
                exp_a    = addr + (j - 1);
                sh       = wdata >> (8 * (j - 1));
                exp_dout = wr ? sh[7:0] : 8'h00;
                exp_done = 1'b0;
                chk("bus_a", bus_a, exp_a);
                chk("bus_wr", {31'd0, bus_wr}, {31'd0, wr});
                chk("bus_dout", {24'd0, bus_dout}, {24'd0, exp_dout});
                chk("done_early", {31'd0, is_mem ? mem_done : if_done}, 32'h0);
            end else begin
                exp_a    = '0;
                exp_done = 1'b1;
                chk("done", {31'd0, is_mem ? mem_done : if_done}, 32'h1);
                chk("other_done", {31'd0, is_mem ? if_done : mem_done}, 32'h0);
                chk("done_bus_wr", {31'd0, bus_wr}, 32'h0);
                chk("done_bus_a", bus_a, 32'h0);
                if (!wr) chk("rdata", is_mem ? mem_rdata : if_data, exp_rd);
            end
            if (j == stall_j) begin
                ready = 1'b0;
                for (int unsigned s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall_bus_a", bus_a, exp_a);
                    chk("stall_bus_wr", {31'd0, bus_wr}, 32'h0);
                    chk("stall_done", {31'd0, is_mem ? mem_done : if_done}, {31'd0, exp_done});
                end
                ready = 1'b1;
            end
            if (j == n + 1) begin
                if (is_mem) mem_req = 1'b0;
                else        if_req  = 1'b0;
                chk("write_count", 32'(wr_count - wc0), wr ? 32'(n) : 32'h0);
            end
        end
        last_mem = is_mem;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk_zero("idle");
    endtask

    task automatic tie(input bit mwe, input logic [1:0] msize, input logic [31:0] maddr,
                       input logic [31:0] mwd, input logic [31:0] iaddr);
        bit first_mem;
`ifdef MEM_ARB_RR_EN
        first_mem = ~last_mem;
`else
        first_mem = 1'b1;
`endif
        raise(1'b1, mwe, msize, maddr, mwd);
        raise(1'b0, 1'b0, 2'b10, iaddr, '0);
        if (first_mem) begin
            serve(1'b1, mwe, msize, maddr, mwd, 0, 0);
            serve(1'b0, 1'b0, 2'b10, iaddr, '0, 0, 0);
        end else begin
            serve(1'b0, 1'b0, 2'b10, iaddr, '0, 0, 0);
            serve(1'b1, mwe, msize, maddr, mwd, 0, 0);
        end
        idle_check();
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 4) == 0) return 32'hFFFF_FFFC + $urandom_range(0, 3);
        return $urandom;
    endfunction

    initial begin
        for (int unsigned i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));
        last_mem  = 1'b0;
        rst       = 1'b0;
        ready     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset.if_data", if_data, 32'h0);
        chk("reset.mem_rdata", mem_rdata, 32'h0);
        rst = 1'b1;

        // Instruction fetch at 0x100
        raise(1'b0, 1'b0, 2'b10, 32'h100, '0);
        serve(1'b0, 1'b0, 2'b10, 32'h100, '0, 0, 0);
        chk("fetch_word", if_data, 32'h0000_0513);
        idle_check();

        // Store word then byte load
        raise(1'b1, 1'b1, 2'b10, 32'h1000, 32'hDEAD_BEEF);
        serve(1'b1, 1'b1, 2'b10, 32'h1000, 32'hDEAD_BEEF, 0, 0);
        idle_check();
        raise(1'b1, 1'b0, 2'b00, 32'h1002, '0);
        serve(1'b1, 1'b0, 2'b00, 32'h1002, '0, 0, 0);
        chk("byte_load", mem_rdata, 32'h0000_00AD);
        idle_check();

        // Store paused for 3 cycles mid-transfer, then read back
        raise(1'b1, 1'b1, 2'b10, 32'h2000, 32'h1234_5678);
        serve(1'b1, 1'b1, 2'b10, 32'h2000, 32'h1234_5678, 2, 3);
        idle_check();
        raise(1'b1, 1'b0, 2'b10, 32'h2000, '0);
        serve(1'b1, 1'b0, 2'b10, 32'h2000, '0, 5, 2);
        chk("stall_readback", mem_rdata, 32'h1234_5678);
        idle_check();

        // Fetch flushed after two bytes, then a fresh fetch at 0x200
        raise(1'b0, 1'b0, 2'b10, 32'h400, '0);
        @(negedge clk);
        chk("flush.a0", bus_a, 32'h400);
        @(negedge clk);
        chk("flush.a1", bus_a, 32'h401);
        if_flush = 1'b1;
        @(negedge clk);
        if_flush = 1'b0;
        chk("flush.bus_a", bus_a, 32'h0);
        chk("flush.if_done", {31'd0, if_done}, 32'h0);
        last_mem = 1'b0;
        if_addr  = 32'h200;
        serve(1'b0, 1'b0, 2'b10, 32'h200, '0, 0, 0);
        idle_check();

        // Reset in the middle of a read
        raise(1'b0, 1'b0, 2'b10, 32'h300, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        chk("midreset.if_data", if_data, 32'h0);
        chk("midreset.mem_rdata", mem_rdata, 32'h0);
        rst      = 1'b1;
        if_req   = 1'b0;
        last_mem = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_zero("post_reset");
        end

        // Ties: first from reset, second after a MEM-only grant
        tie(1'b0, 2'b10, 32'h1000, '0, 32'h100);
        raise(1'b1, 1'b0, 2'b01, 32'h1002, '0);
        serve(1'b1, 1'b0, 2'b01, 32'h1002, '0, 0, 0);
        chk("half_load", mem_rdata, 32'h0000_DEAD);
        idle_check();
        tie(1'b1, 2'b01, 32'h3000, 32'h0000_CAFE, 32'h3000);

        // Randomized traffic
        for (int unsigned it = 0; it < 40; it++) begin
            bit          is_mem, we;
            logic [1:0]  size;
            logic [31:0] addr, wd;
            int unsigned sj, sl, n;
            is_mem = 1'($urandom);
            we     = 1'($urandom);
            size   = 2'($urandom);
            addr   = rnd_addr();
            wd     = $urandom;
            n      = is_mem ? nbytes(size) : 4;
            sj     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : 0;
            sl     = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) begin
                tie(we, size, addr, wd, rnd_addr());
            end else begin
                raise(is_mem, we, size, addr, wd);
                serve(is_mem, we, size, addr, wd, sj, sl);
                idle_check();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
